// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg: shared FSM encoding, queue entry layout and error word
package instr_prefetch_pkg;
  typedef enum logic [1:0] {PF_IDLE, PF_FETCH, PF_DISCARD} pf_state_t;
  localparam logic [15:0] PF_ERRWORD = 16'h0000;
  typedef struct packed {
    logic        err;
    logic [15:0] word;
  } pf_entry_t;
endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: instruction-space read bus between prefetcher and bus interface unit
interface instr_prefetch_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [15:0] if_data;
  modport master (output if_req, if_addr, input if_ack, if_err, if_data);
  modport slave (input if_req, if_addr, output if_ack, if_err, if_data);
endinterface

// File: rtl/instr_prefetch_fifo.sv
// instr_prefetch_fifo: DEPTH-entry circular queue of {err,word} with flush, registered head
module instr_prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  pf_entry_t     din,
  output pf_entry_t     head,
  output logic [CW-1:0] cnt
);
  pf_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign head = mem[rd];
  // flush restarts the queue at slot 0 and may take a push in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= push ? inc('0) : '0;
      cnt <= CW'(push);
      if (push) mem[0] <= din;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= inc(wr);
      end
      if (pop) rd <= inc(rd);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && !flush && cnt == CW'(DEPTH)));
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: fetch FSM, fetch PC and ir_pc tracking in front of the decoder queue
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'o000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [15:0]       pc_new,
  input  logic              ir_take,
  output logic              ir_valid,
  output logic [15:0]       idc_opc,
  output logic              ir_err,
  output logic [15:0]       ir_pc,
  instr_prefetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  pf_state_t state, state_nxt;
  logic [15:0] fetch_pc, pc_nxt, addr_q;
  logic stopped, stop_nxt, done, busy, push, pop, issue;
  logic [CW-1:0] cnt, cnt_after;
  pf_entry_t din, head;
  instr_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk, .reset_n, .flush(pc_load), .push, .pop, .din, .head, .cnt
  );
  assign ir_valid     = cnt != '0;
  assign idc_opc      = head.word;
  assign ir_err       = ir_valid & head.err;
  assign bus.if_req   = state != PF_IDLE;
  assign bus.if_addr  = addr_q;
  // a new request may issue only once the bus is free and the queue still has room after this cycle
  always_comb begin
    done      = bus.if_ack | bus.if_err;
    busy      = (state != PF_IDLE) & ~done;
    pc_nxt    = pc_load ? pc_new : ((state == PF_FETCH) & bus.if_ack) ? fetch_pc + 16'd2 : fetch_pc;
    stop_nxt  = pc_load ? pc_new[0] : stopped | ((state == PF_FETCH) & bus.if_err);
    push      = pc_load ? pc_new[0] : (state == PF_FETCH) & done;
    din       = (pc_load | bus.if_err) ? {1'b1, PF_ERRWORD} : {1'b0, bus.if_data};
    pop       = ir_take & ir_valid & ~pc_load;
    cnt_after = pc_load ? CW'(pc_new[0]) : cnt + CW'(push) - CW'(pop);
    issue     = ~busy & fetch_en & ~stop_nxt & (cnt_after < CW'(DEPTH));
    state_nxt = busy ? ((pc_load | (state == PF_DISCARD)) ? PF_DISCARD : PF_FETCH)
                     : issue ? PF_FETCH : PF_IDLE;
  end
  // bus address is held while a request is pending; ir_pc follows the head word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PF_IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      stopped  <= 1'b0;
      ir_pc    <= RESET_PC + 16'd2;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
      stopped  <= stop_nxt;
      if (issue) addr_q <= pc_nxt;
      ir_pc    <= pc_load ? pc_new + 16'd2 : pop ? ir_pc + 16'd2 : ir_pc;
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed scenarios plus randomized run against a word-stream model
module tb_instr_prefetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, fetch_en, pc_load, ir_take;
  logic [15:0] pc_new;
  logic ir_valid, ir_err;
  logic [15:0] idc_opc, ir_pc;
  instr_prefetch_if bus ();
  instr_prefetch #(.DEPTH(2), .RESET_PC(16'o000000)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .pc_load(pc_load), .pc_new(pc_new),
    .ir_take(ir_take), .ir_valid(ir_valid), .idc_opc(idc_opc), .ir_err(ir_err), .ir_pc(ir_pc),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  logic auto_bus = 1'b1;
  logic lat_rand = 1'b0;
  int lat_cfg = 0;
  logic [15:0] err_addr = 16'h0001;
  logic r_ack = 1'b0, r_err = 1'b0, m_ack = 1'b0, m_err = 1'b0;
  logic [15:0] r_data = 16'h0, m_data = 16'h0;
  logic [15:0] req_log [$];
  assign bus.if_ack  = auto_bus ? r_ack : m_ack;
  assign bus.if_err  = auto_bus ? r_err : m_err;
  assign bus.if_data = auto_bus ? r_data : m_data;

  function automatic logic [15:0] wdata(input logic [15:0] a);
    return a == 16'o1000 ? 16'o012700 : a == 16'o1002 ? 16'o000005 : a ^ 16'hA5C3;
  endfunction

  // bus unit model: answers each request after a configurable number of wait cycles
  initial begin
    int wcnt, tgt;
    wcnt = 0;
    tgt = 0;
    forever begin
      @(negedge clk);
      r_ack = 1'b0;
      r_err = 1'b0;
      if (bus.if_req === 1'b1) begin
        if (wcnt == 0) tgt = lat_rand ? int'($urandom_range(0, 2)) : lat_cfg;
        if (wcnt >= tgt) begin
          if (bus.if_addr == err_addr) r_err = 1'b1;
          else begin
            r_ack = 1'b1;
            r_data = wdata(bus.if_addr);
          end
          req_log.push_back(bus.if_addr);
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b want 0", ir_valid); end
    checks++; if (ir_err !== 1'b0) begin errors++; $display("FAIL reset_ir_err got %b want 0", ir_err); end
    checks++; if (idc_opc !== 16'h0) begin errors++; $display("FAIL reset_idc_opc got %o want 0", idc_opc); end
    checks++; if (ir_pc !== 16'o2) begin errors++; $display("FAIL reset_ir_pc got %o want 2", ir_pc); end
    checks++; if (bus.if_req !== 1'b0) begin errors++; $display("FAIL reset_if_req got %b want 0", bus.if_req); end
    checks++; if (bus.if_addr !== 16'o0) begin errors++; $display("FAIL reset_if_addr got %o want 0", bus.if_addr); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int base;
    base = req_log.size();
    lat_cfg = 0;
    fetch_en = 1'b1;
    pc_load = 1'b1;
    pc_new = 16'o1000;
    tick;
    pc_load = 1'b0;
    checks++; if (bus.if_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", bus.if_req); end
    checks++; if (bus.if_addr !== 16'o1000) begin errors++; $display("FAIL basic_addr0 got %o want 1000", bus.if_addr); end
    tick;
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", ir_valid); end
    checks++; if (idc_opc !== 16'o012700) begin errors++; $display("FAIL basic_opc0 got %o want 012700", idc_opc); end
    checks++; if (ir_pc !== 16'o1002) begin errors++; $display("FAIL basic_pc0 got %o want 1002", ir_pc); end
    checks++; if (bus.if_addr !== 16'o1002) begin errors++; $display("FAIL basic_addr1 got %o want 1002", bus.if_addr); end
    repeat (4) tick;
    checks++; if (bus.if_req !== 1'b0) begin errors++; $display("FAIL basic_full_req got %b want 0", bus.if_req); end
    checks++; if (req_log.size() - base != 2) begin errors++; $display("FAIL basic_nfetch got %0d want 2", req_log.size() - base); end
    ir_take = 1'b1;
    tick;
    ir_take = 1'b0;
    checks++; if (idc_opc !== 16'o000005) begin errors++; $display("FAIL basic_opc1 got %o want 000005", idc_opc); end
    checks++; if (ir_pc !== 16'o1004) begin errors++; $display("FAIL basic_pc1 got %o want 1004", ir_pc); end
    checks++; if (bus.if_req !== 1'b1 || bus.if_addr !== 16'o1004) begin errors++; $display("FAIL basic_refetch got req=%b addr=%o want req=1 addr=1004", bus.if_req, bus.if_addr); end
    repeat (3) tick;
    checks++; if (req_log.size() - base != 3 || bus.if_req !== 1'b0) begin errors++; $display("FAIL basic_nfetch2 got %0d req=%b want 3 req=0", req_log.size() - base, bus.if_req); end
  endtask

  task automatic test_discard;
    int base;
    base = req_log.size();
    lat_cfg = 3;
    pc_load = 1'b1;
    pc_new = 16'o1000;
    tick;
    pc_load = 1'b0;
    checks++; if (bus.if_req !== 1'b1 || bus.if_addr !== 16'o1000) begin errors++; $display("FAIL disc_start got req=%b addr=%o want 1/1000", bus.if_req, bus.if_addr); end
    pc_load = 1'b1;
    pc_new = 16'o2000;
    tick;
    pc_load = 1'b0;
    checks++; if (bus.if_req !== 1'b1 || bus.if_addr !== 16'o1000) begin errors++; $display("FAIL disc_hold got req=%b addr=%o want 1/1000", bus.if_req, bus.if_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL disc_empty got %b want 0", ir_valid); end
    for (int i = 0; i < 20 && ir_valid !== 1'b1; i++) tick;
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL disc_timeout got %b want 1", ir_valid); end
    checks++; if (idc_opc !== wdata(16'o2000)) begin errors++; $display("FAIL disc_opc got %o want %o", idc_opc, wdata(16'o2000)); end
    checks++; if (ir_pc !== 16'o2002) begin errors++; $display("FAIL disc_pc got %o want 2002", ir_pc); end
    checks++; if (req_log.size() < base + 2 || req_log[base] !== 16'o1000 || req_log[base+1] !== 16'o2000) begin errors++; $display("FAIL disc_order got n=%0d want 1000 then 2000", req_log.size() - base); end
    lat_cfg = 0;
  endtask

  task automatic test_error;
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    err_addr = 16'o1004;
    pc_load = 1'b1;
    pc_new = 16'o1000;
    tick;
    pc_load = 1'b0;
    ir_take = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (seen) begin
        checks++; if (bus.if_req !== 1'b0) begin errors++; $display("FAIL err_stopped_req got %b want 0", bus.if_req); end
      end
      if (ir_valid === 1'b1) begin
        if (k < 2) begin
          checks++; if (ir_err !== 1'b0 || idc_opc !== wdata(16'o1000 + 16'(2 * k))) begin errors++; $display("FAIL err_word%0d got err=%b opc=%o want 0/%o", k, ir_err, idc_opc, wdata(16'o1000 + 16'(2 * k))); end
        end else if (k == 2) begin
          checks++; if (ir_err !== 1'b1 || idc_opc !== 16'h0) begin errors++; $display("FAIL err_marker got err=%b opc=%o want 1/0", ir_err, idc_opc); end
          checks++; if (bus.if_req !== 1'b0) begin errors++; $display("FAIL err_marker_req got %b want 0", bus.if_req); end
          seen = 1'b1;
        end else begin
          checks++; errors++; $display("FAIL err_extra got entry %0d want none", k);
        end
        k++;
      end
      tick;
    end
    ir_take = 1'b0;
    checks++; if (k != 3) begin errors++; $display("FAIL err_count got %0d want 3", k); end
    err_addr = 16'h0001;
  endtask

  task automatic test_wrap_odd;
    int k;
    k = 0;
    pc_load = 1'b1;
    pc_new = 16'o177776;
    tick;
    pc_load = 1'b0;
    ir_take = 1'b1;
    for (int i = 0; i < 20 && k < 2; i++) begin
      if (ir_valid === 1'b1) begin
        if (k == 0) begin
          checks++; if (idc_opc !== wdata(16'o177776) || ir_pc !== 16'o0) begin errors++; $display("FAIL wrap_w0 got opc=%o pc=%o want %o/0", idc_opc, ir_pc, wdata(16'o177776)); end
        end else begin
          checks++; if (idc_opc !== wdata(16'o0) || ir_pc !== 16'o2) begin errors++; $display("FAIL wrap_w1 got opc=%o pc=%o want %o/2", idc_opc, ir_pc, wdata(16'o0)); end
        end
        k++;
      end
      tick;
    end
    checks++; if (k != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", k); end
    ir_take = 1'b0;
    fetch_en = 1'b0;
    for (int i = 0; i < 20 && bus.if_req !== 1'b0; i++) tick;
    checks++; if (bus.if_req !== 1'b0) begin errors++; $display("FAIL wrap_drain got %b want 0", bus.if_req); end
    fetch_en = 1'b1;
    pc_load = 1'b1;
    pc_new = 16'o1001;
    tick;
    pc_load = 1'b0;
    checks++; if (ir_valid !== 1'b1 || ir_err !== 1'b1 || idc_opc !== 16'h0) begin errors++; $display("FAIL odd_entry got v=%b e=%b opc=%o want 1/1/0", ir_valid, ir_err, idc_opc); end
    checks++; if (ir_pc !== 16'o1003) begin errors++; $display("FAIL odd_pc got %o want 1003", ir_pc); end
    checks++; if (bus.if_req !== 1'b0) begin errors++; $display("FAIL odd_req got %b want 0", bus.if_req); end
    repeat (3) tick;
    checks++; if (bus.if_req !== 1'b0 || ir_valid !== 1'b1) begin errors++; $display("FAIL odd_stopped got req=%b v=%b want 0/1", bus.if_req, ir_valid); end
  endtask

  task automatic test_same_cycle;
    auto_bus = 1'b0;
    m_ack = 1'b0;
    pc_load = 1'b1;
    pc_new = 16'o3000;
    tick;
    pc_load = 1'b0;
    checks++; if (bus.if_req !== 1'b1 || bus.if_addr !== 16'o3000) begin errors++; $display("FAIL same_start got req=%b addr=%o want 1/3000", bus.if_req, bus.if_addr); end
    tick;
    m_ack = 1'b1;
    m_data = 16'hDEAD;
    pc_load = 1'b1;
    pc_new = 16'o4000;
    tick;
    m_ack = 1'b0;
    pc_load = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL same_ack_drop got %b want 0", ir_valid); end
    checks++; if (bus.if_req !== 1'b1 || bus.if_addr !== 16'o4000) begin errors++; $display("FAIL same_ack_next got req=%b addr=%o want 1/4000", bus.if_req, bus.if_addr); end
    checks++; if (ir_pc !== 16'o4002) begin errors++; $display("FAIL same_ack_pc got %o want 4002", ir_pc); end
    m_ack = 1'b1;
    m_data = 16'h1234;
    tick;
    m_ack = 1'b0;
    checks++; if (ir_valid !== 1'b1 || idc_opc !== 16'h1234) begin errors++; $display("FAIL same_word got v=%b opc=%h want 1/1234", ir_valid, idc_opc); end
    ir_take = 1'b1;
    pc_load = 1'b1;
    pc_new = 16'o5000;
    tick;
    ir_take = 1'b0;
    pc_load = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL same_take_flush got %b want 0", ir_valid); end
    checks++; if (ir_pc !== 16'o5002) begin errors++; $display("FAIL same_take_pc got %o want 5002", ir_pc); end
    m_ack = 1'b1;
    m_data = 16'hBEEF;
    tick;
    m_ack = 1'b0;
    checks++; if (bus.if_req !== 1'b1 || bus.if_addr !== 16'o5000 || ir_valid !== 1'b0) begin errors++; $display("FAIL same_take_next got req=%b addr=%o v=%b want 1/5000/0", bus.if_req, bus.if_addr, ir_valid); end
    auto_bus = 1'b1;
  endtask

  task automatic test_random;
    logic [15:0] m_addr, r;
    logic m_dead, ld, tk;
    int starve;
    m_addr = 16'h0;
    m_dead = 1'b0;
    starve = 0;
    lat_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i > 0) begin
        checks++; if (ir_pc !== m_addr + 16'd2) begin errors++; $display("FAIL rnd_ir_pc cyc %0d got %o want %o", i, ir_pc, m_addr + 16'd2); end
        if (ir_valid === 1'b1) begin
          checks++;
          if (m_addr[0] || m_addr == err_addr) begin
            if (ir_err !== 1'b1 || idc_opc !== 16'h0) begin errors++; $display("FAIL rnd_err cyc %0d addr %o got e=%b opc=%o want 1/0", i, m_addr, ir_err, idc_opc); end
          end else if (ir_err !== 1'b0 || idc_opc !== wdata(m_addr)) begin
            errors++; $display("FAIL rnd_word cyc %0d addr %o got e=%b opc=%o want 0/%o", i, m_addr, ir_err, idc_opc, wdata(m_addr));
          end
        end
        if (m_dead) begin
          checks++; if (ir_valid !== 1'b0 || bus.if_req !== 1'b0) begin errors++; $display("FAIL rnd_stopped cyc %0d got v=%b req=%b want 0/0", i, ir_valid, bus.if_req); end
        end
        starve = (ir_valid !== 1'b1 && !m_dead) ? starve + 1 : 0;
        checks++; if (starve > 40) begin errors++; $display("FAIL rnd_starve cyc %0d got %0d idle cycles want <=40", i, starve); starve = 0; end
      end
      r = 16'($urandom);
      ld = (i == 0) || ($urandom_range(0, 19) == 0);
      tk = 1'($urandom_range(0, 1));
      fetch_en = ($urandom_range(0, 9) != 0);
      pc_load = ld;
      ir_take = tk;
      if (ld) begin
        pc_new = ($urandom_range(0, 5) == 0) ? (r | 16'h0001) : (r & 16'hFFFE);
        m_addr = pc_new;
        m_dead = 1'b0;
        err_addr = ($urandom_range(0, 2) == 0) ? pc_new + 16'(2 * $urandom_range(1, 4)) : 16'h0001;
        starve = 0;
      end else if (tk && ir_valid === 1'b1) begin
        if (ir_err === 1'b1) m_dead = 1'b1;
        m_addr = m_addr + 16'd2;
      end
      tick;
    end
    pc_load = 1'b0;
    ir_take = 1'b0;
    lat_rand = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_en = 1'b0;
    pc_load = 1'b0;
    pc_new = 16'h0;
    ir_take = 1'b0;
    test_reset;
    test_basic;
    test_discard;
    test_error;
    test_wrap_odd;
    test_same_cycle;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
